// File: rtl/phy_pkg.sv
// Shared PHY definitions: the COM alignment symbol, receive FSM state encoding and
// the default number of aligned COMs needed to declare a lane active.
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam int unsigned COM_COUNT_DEF = 4;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register, MSB first. nxt is the combinational view of
// the register after the current bit is shifted in, so the FSM can act on it this edge.
module sipo_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk_32f,
  input  logic              clear,
  input  logic              data_in,
  output logic [DATA_W-1:0] sr,
  output logic [DATA_W-1:0] nxt
);

  logic [DATA_W-1:0] sr_r;

  assign nxt = {sr_r[DATA_W-2:0], data_in};
  assign sr  = sr_r;

  // shift one bit per edge; clear wins over shifting
  always_ff @(posedge clk_32f) begin
    if (clear) begin
      sr_r <= {DATA_W{1'b0}};
    end else begin
      sr_r <= nxt;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Per-lane serial-to-parallel receiver: aligns to the COM symbol, declares the lane
// active after COM_COUNT aligned COMs, then strobes out every non-COM byte.
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] COM     = COM_SYMBOL,
  parameter int              COM_COUNT = COM_COUNT_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [3:0]        COM_LAST = 4'(COM_COUNT - 1);

  logic [DATA_W-1:0] sr_unused_s;
  logic [DATA_W-1:0] nxt_s;

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_s;
  logic [CNT_W-1:0]  bit_inc_s;
  logic [3:0]        com_cnt_r;
  logic [3:0]        com_cnt_s;

  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] data_out_s;
  logic              valid_out_r;
  logic              valid_out_s;
  logic              active_r;
  logic              active_s;

  logic              boundary_s;
  logic              com_hit_s;
  logic              last_com_s;

  sipo_shift #(
    .DATA_W (DATA_W)
  ) u_sipo_shift (
    .clk_32f (clk_32f),
    .clear   (reset),
    .data_in (data_in),
    .sr      (sr_unused_s),
    .nxt     (nxt_s)
  );

  assign boundary_s = (bit_cnt_r == LAST_BIT);
  assign com_hit_s  = (nxt_s == COM);
  assign last_com_s = (com_cnt_r == COM_LAST);
  assign bit_inc_s  = boundary_s ? {CNT_W{1'b0}} : bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // state, counters and registered outputs
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_r     <= ST_HUNT;
      bit_cnt_r   <= {CNT_W{1'b0}};
      com_cnt_r   <= 4'd0;
      data_out_r  <= {DATA_W{1'b0}};
      valid_out_r <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      com_cnt_r   <= com_cnt_s;
      data_out_r  <= data_out_s;
      valid_out_r <= valid_out_s;
      active_r    <= active_s;
    end
  end

  // next state: sliding COM search in HUNT, boundary-only checks once locked
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    com_cnt_s = com_cnt_r;
    case (state_r)
      ST_HUNT: begin
        bit_cnt_s = {CNT_W{1'b0}};
        if (com_hit_s) begin
          state_s   = ST_SYNC;
          com_cnt_s = 4'd1;
        end else begin
          state_s   = ST_HUNT;
          com_cnt_s = 4'd0;
        end
      end
      ST_SYNC: begin
        bit_cnt_s = bit_inc_s;
        if (boundary_s && com_hit_s) begin
          if (last_com_s) begin
            state_s = ST_ACTIVE;
          end else begin
            com_cnt_s = com_cnt_r + 4'd1;
          end
        end else if (boundary_s) begin
          // lost alignment: the failing window is not re-searched on this edge
          state_s   = ST_HUNT;
          com_cnt_s = 4'd0;
          bit_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_ACTIVE: begin
        state_s   = ST_ACTIVE;
        bit_cnt_s = bit_inc_s;
      end
      default: begin
        state_s   = ST_HUNT;
        bit_cnt_s = {CNT_W{1'b0}};
        com_cnt_s = 4'd0;
      end
    endcase
  end

  // next output values; valid is a single-cycle strobe on data boundaries only
  always_comb begin
    data_out_s  = data_out_r;
    valid_out_s = 1'b0;
    active_s    = active_r;
    case (state_r)
      ST_SYNC: begin
        if (boundary_s && com_hit_s && last_com_s) begin
          active_s = 1'b1;
        end else begin
          active_s = active_r;
        end
      end
      ST_ACTIVE: begin
        if (boundary_s && !com_hit_s) begin
          data_out_s  = nxt_s;
          valid_out_s = 1'b1;
        end else begin
          data_out_s  = data_out_r;
          valid_out_s = 1'b0;
        end
      end
      default: begin
        data_out_s  = data_out_r;
        valid_out_s = 1'b0;
        active_s    = active_r;
      end
    endcase
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign active    = active_r;

endmodule
